// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   owner_t     : which port won most recently (P0 = cpu, P1 = debug/loader)
//   LAST_RST    : reset owner, chosen so the first tie after reset goes to port 0
//   RD_PEND_RST : reset value of the pending-read flag
// Optional feature macro: MEM_ARB_LOCK_EN (adds lock0/lock1 burst locking).
package mem_arb_pkg;

    typedef enum logic {
        P0 = 1'b0,
        P1 = 1'b1
    } owner_t;

    localparam int     ADDR_WIDTH_DEF = 6;
    localparam int     DATA_WIDTH_DEF = 16;
    localparam owner_t LAST_RST       = P1;
    localparam logic   RD_PEND_RST    = 1'b0;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way picker.
// Ports:
//   req0, req1   : requests from port 0 / port 1
//   last         : most recent winner
//   lock0, lock1 : (MEM_ARB_LOCK_EN only) burst lock from the current owner
//   gnt          : one-hot grant, bit N = port N, all-zero when nobody asks
// A lone requester always wins. On a tie the port that did not win last
// time gets the grant, unless the last winner is holding its lock.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  owner_t     last,
`ifdef MEM_ARB_LOCK_EN
    input  logic       lock0,
    input  logic       lock1,
`endif
    output logic [1:0] gnt
);

    logic hold0;
    logic hold1;

    always_comb begin
        hold0 = 1'b0;
        hold1 = 1'b0;
`ifdef MEM_ARB_LOCK_EN
        // Lock only counts for the port that currently owns the memory.
        hold0 = (last == P0) && req0 && lock0;
        hold1 = (last == P1) && req1 && lock1;
`endif
        gnt = 2'b00;
        if (req0 && req1) begin
            if (hold0)            gnt = 2'b01;
            else if (hold1)       gnt = 2'b10;
            else if (last == P0)  gnt = 2'b10;
            else                  gnt = 2'b01;
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous-read memory.
// Port 0 is the cpu, port 1 the debug/loader master.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN/weN/addrN/wdataN : access request (held until gntN), write flag, address, write data
//   lock0/lock1           : (MEM_ARB_LOCK_EN only) owner keeps the memory while req&lock
//   gntN                  : access accepted this cycle (combinational)
//   rvalidN/rdataN        : read return, one cycle after the read grant
//   mem_we/addr/data      : memory command, driven by the winner in the grant cycle
//   mem_in                : memory read data, valid the cycle after the address
//   dbg_last              : arbitration state (most recent winner)
// Handshake: reqN is held until gntN; gntN=1 means the access was issued to
// memory in that same cycle. rvalidN is a one-cycle strobe, no back-pressure.
// Optional feature macro: MEM_ARB_LOCK_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
    input  logic                  lock0,
    input  logic                  lock1,
`endif
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    input  logic [DATA_WIDTH-1:0] mem_in,
    output owner_t                dbg_last
);

    owner_t                last;
    owner_t                last_next;
    owner_t                rd_src;
    logic                  rd_pend;
    logic [1:0]            gnt;
    logic [DATA_WIDTH-1:0] rdata0_q;
    logic [DATA_WIDTH-1:0] rdata1_q;

    // Requests are masked during reset so no grant or memory command
    // leaks out while rst_n is low.
    rr_pick2 u_pick (
        .req0  (req0 & rst_n),
        .req1  (req1 & rst_n),
        .last  (last),
`ifdef MEM_ARB_LOCK_EN
        .lock0 (lock0),
        .lock1 (lock1),
`endif
        .gnt   (gnt)
    );

    assign gnt0     = gnt[0];
    assign gnt1     = gnt[1];
    assign dbg_last = last;

    // Memory command mux: zeros when idle.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (gnt[0]) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_data = wdata0;
        end else if (gnt[1]) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_data = wdata1;
        end
    end

    // Arbitration state: moves only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last <= LAST_RST;
        else        last <= last_next;
    end

    always_comb begin
        last_next = last;
        if (gnt[0])      last_next = P0;
        else if (gnt[1]) last_next = P1;
    end

    // Read-return tracking: one outstanding read at most, returned next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= RD_PEND_RST;
            rd_src  <= P0;
        end else begin
            rd_pend <= (gnt[0] && !we0) || (gnt[1] && !we1);
            rd_src  <= gnt[1] ? P1 : P0;
        end
    end

    assign rvalid0 = rd_pend && (rd_src == P0);
    assign rvalid1 = rd_pend && (rd_src == P1);

    // mem_in is only valid in the return cycle, so it is forwarded then and
    // captured for display until the next return to the same port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (rvalid0) rdata0_q <= mem_in;
            if (rvalid1) rdata1_q <= mem_in;
        end
    end

    assign rdata0 = rvalid0 ? mem_in : rdata0_q;
    assign rdata1 = rvalid1 ? mem_in : rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
    logic [5:0]  addr0 = 0, addr1 = 0;
    logic [15:0] wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata0, rdata1, mem_data;
    logic [15:0] mem_in = 16'h0;
    logic [5:0]  mem_addr;
    owner_t      dbg_last;
`ifdef MEM_ARB_LOCK_EN
    logic        lock0 = 0, lock1 = 0;
`endif

    mem_arbiter #(.ADDR_WIDTH(6), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef MEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_in(mem_in), .dbg_last(dbg_last)
    );

    // Memory model: sync read, write-first, preset to 16'h1000+addr in reset.
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
            mem_in <= 16'h0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_data;
            mem_in <= mem_we ? mem_data : mem[mem_addr];
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic        req0, we0;
        logic [5:0]  addr0;
        logic [15:0] wdata0;
        logic        req1, we1;
        logic [5:0]  addr1;
        logic [15:0] wdata1;
        logic        g0, g1, rv0, rv1;
        logic [15:0] rd0, rd1;
        logic        mwe;
        logic [5:0]  maddr;
        logic [15:0] mdata;
    } vec_t;

    vec_t vecs[15];

    // ---------------- drivers ----------------
    task automatic drive(input logic r0, input logic w0, input logic [5:0] a0, input logic [15:0] d0,
                         input logic r1, input logic w1, input logic [5:0] a1, input logic [15:0] d1);
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].req0, vecs[i].we0, vecs[i].addr0, vecs[i].wdata0,
                  vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].wdata1);
            @(negedge clk);
            chk($sformatf("vec%0d gnt0", i),    32'(gnt0),     32'(vecs[i].g0));
            chk($sformatf("vec%0d gnt1", i),    32'(gnt1),     32'(vecs[i].g1));
            chk($sformatf("vec%0d rvalid0", i), 32'(rvalid0),  32'(vecs[i].rv0));
            chk($sformatf("vec%0d rvalid1", i), 32'(rvalid1),  32'(vecs[i].rv1));
            chk($sformatf("vec%0d rdata0", i),  32'(rdata0),   32'(vecs[i].rd0));
            chk($sformatf("vec%0d rdata1", i),  32'(rdata1),   32'(vecs[i].rd1));
            chk($sformatf("vec%0d mem_we", i),  32'(mem_we),   32'(vecs[i].mwe));
            chk($sformatf("vec%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
            chk($sformatf("vec%0d mem_data", i), 32'(mem_data), 32'(vecs[i].mdata));
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // req0 we0 a0 d0 | req1 we1 a1 d1 | g0 g1 rv0 rv1 | rd0 rd1 | mwe maddr mdata
        // Both read every cycle: alternation 0,1,0,1 from reset.
        vecs[0]  = '{1'b1,1'b0,6'd1,16'h0, 1'b1,1'b0,6'd2,16'h0, 1'b1,1'b0,1'b0,1'b0, 16'h0000,16'h0000, 1'b0,6'd1,16'h0};
        vecs[1]  = '{1'b1,1'b0,6'd1,16'h0, 1'b1,1'b0,6'd2,16'h0, 1'b0,1'b1,1'b1,1'b0, 16'h1001,16'h0000, 1'b0,6'd2,16'h0};
        vecs[2]  = '{1'b1,1'b0,6'd1,16'h0, 1'b1,1'b0,6'd2,16'h0, 1'b1,1'b0,1'b0,1'b1, 16'h1001,16'h1002, 1'b0,6'd1,16'h0};
        vecs[3]  = '{1'b1,1'b0,6'd1,16'h0, 1'b1,1'b0,6'd2,16'h0, 1'b0,1'b1,1'b1,1'b0, 16'h1001,16'h1002, 1'b0,6'd2,16'h0};
        vecs[4]  = '{1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b0,1'b1, 16'h1001,16'h1002, 1'b0,6'd0,16'h0};
        // Port 0 alone: write 5, read 5.
        vecs[5]  = '{1'b1,1'b1,6'd5,16'h00A5, 1'b0,1'b0,6'd0,16'h0, 1'b1,1'b0,1'b0,1'b0, 16'h1001,16'h1002, 1'b1,6'd5,16'h00A5};
        vecs[6]  = '{1'b1,1'b0,6'd5,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b1,1'b0,1'b0,1'b0, 16'h1001,16'h1002, 1'b0,6'd5,16'h0};
        vecs[7]  = '{1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b1,1'b0, 16'h00A5,16'h1002, 1'b0,6'd0,16'h0};
        // Port 1 writes 7, port 0 reads 7 next cycle.
        vecs[8]  = '{1'b0,1'b0,6'd0,16'h0, 1'b1,1'b1,6'd7,16'h1234, 1'b0,1'b1,1'b0,1'b0, 16'h00A5,16'h1002, 1'b1,6'd7,16'h1234};
        vecs[9]  = '{1'b1,1'b0,6'd7,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b1,1'b0,1'b0,1'b0, 16'h00A5,16'h1002, 1'b0,6'd7,16'h0};
        vecs[10] = '{1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b1,1'b0, 16'h1234,16'h1002, 1'b0,6'd0,16'h0};
        // After 10 idle cycles last is still P0: tie goes to port 1.
        vecs[11] = '{1'b1,1'b0,6'd1,16'h0, 1'b1,1'b0,6'd2,16'h0, 1'b0,1'b1,1'b0,1'b0, 16'h1234,16'h1002, 1'b0,6'd2,16'h0};
        vecs[12] = '{1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b0,1'b1, 16'h1234,16'h1002, 1'b0,6'd0,16'h0};
        // Tie to port 0, then the losing port 1 withdraws without a grant.
        vecs[13] = '{1'b1,1'b0,6'd3,16'h0, 1'b1,1'b0,6'd4,16'h0, 1'b1,1'b0,1'b0,1'b0, 16'h1234,16'h1002, 1'b0,6'd3,16'h0};
        vecs[14] = '{1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,6'd0,16'h0, 1'b0,1'b0,1'b1,1'b0, 16'h1003,16'h1002, 1'b0,6'd0,16'h0};

        // Reset and check reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset gnt0", 32'(gnt0), 32'd0);
        chk("reset gnt1", 32'(gnt1), 32'd0);
        chk("reset rvalid0", 32'(rvalid0), 32'd0);
        chk("reset rvalid1", 32'(rvalid1), 32'd0);
        chk("reset rdata0", 32'(rdata0), 32'd0);
        chk("reset rdata1", 32'(rdata1), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_addr", 32'(mem_addr), 32'd0);
        chk("reset mem_data", 32'(mem_data), 32'd0);
        chk("reset last", 32'(dbg_last), 32'(P1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_vecs(0, 10);

        // Idle for 10 cycles: nothing issued, last holds.
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            chk($sformatf("idle%0d gnt", i), 32'({gnt0, gnt1}), 32'd0);
            chk($sformatf("idle%0d mem_we", i), 32'(mem_we), 32'd0);
            chk($sformatf("idle%0d rvalid", i), 32'({rvalid0, rvalid1}), 32'd0);
            chk($sformatf("idle%0d last", i), 32'(dbg_last), 32'(P0));
        end

        run_vecs(11, 14);

        // Read granted to port 1, reset one cycle later: no return.
        drive(0, 0, 0, 0, 1, 0, 6'd2, 0);
        @(negedge clk);
        chk("rst_mid gnt1", 32'(gnt1), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid rvalid1", 32'(rvalid1), 32'd0);
        chk("rst_mid rvalid0", 32'(rvalid0), 32'd0);
        chk("rst_mid rdata0", 32'(rdata0), 32'd0);
        chk("rst_mid rdata1", 32'(rdata1), 32'd0);
        chk("rst_mid gnt", 32'({gnt0, gnt1}), 32'd0);
        chk("rst_mid mem", 32'({mem_we, mem_addr, mem_data}), 32'd0);
        chk("rst_mid last", 32'(dbg_last), 32'(P1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_post rvalid1", 32'(rvalid1), 32'd0);
        drive(1, 0, 6'd1, 0, 1, 0, 6'd2, 0);
        @(negedge clk);
        chk("rst_post tie gnt0", 32'(gnt0), 32'd1);
        chk("rst_post tie gnt1", 32'(gnt1), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_post rvalid0", 32'(rvalid0), 32'd1);
        chk("rst_post rdata0", 32'(rdata0), 32'h1001);

`ifdef MEM_ARB_LOCK_EN
        // Port 1 wins alone, then locks for a 4-word burst while port 0 waits.
        drive(0, 0, 0, 0, 1, 0, 6'd10, 0);
        @(negedge clk);
        chk("lock start gnt1", 32'(gnt1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 6'd9, 0, 1, 1, 6'(i), 16'hB000 + 16'(i));
            lock1 = 1'b1;
            @(negedge clk);
            chk($sformatf("lock%0d gnt1", i), 32'(gnt1), 32'd1);
            chk($sformatf("lock%0d gnt0", i), 32'(gnt0), 32'd0);
            chk($sformatf("lock%0d mem_addr", i), 32'(mem_addr), 32'(i));
        end
        drive(1, 0, 6'd9, 0, 0, 0, 0, 0);
        lock1 = 1'b0;
        @(negedge clk);
        chk("lock release gnt0", 32'(gnt0), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
